// File: rtl/gtrg_dav_fifo_n.sv
// Global-trigger DAV FIFO: delayed trigger pushes tagged with BX count,
// windowed DAV pattern and DAV mismatch, buffered for readout.
module gtrg_dav_fifo_n #(
    parameter int NCH       = 7,
    parameter int AW        = 10,
    parameter int BXW       = 12,
    parameter int BX_MAX    = 3563,
    parameter int WIN       = 5,
    parameter int AF_THRESH = 1000
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             BC0,
    input  logic [NCH-1:0]   DAV,
    input  logic [NCH-1:0]   KILL,
    input  logic [NCH-1:0]   EXPECT,
    input  logic [4:0]       PUSHDLY,
    input  logic [3:0]       DAVDLY,
    input  logic             ERRCLR,
    output logic             DPUSH,
    output logic             EMPTY_B,
    output logic             FULL,
    output logic             AFULL,
    output logic [AW:0]      WCOUNT,
    output logic [BXW-1:0]   BXCOUNT,
    output logic [BXW-1:0]   DOUT_BX,
    output logic [NCH-1:0]   DOUT_DAV,
    output logic [NCH-1:0]   DOUT_ERR,
    output logic             DOUT_VALID,
    output logic             OVFL,
    output logic             UNFL
);

    localparam int EW = BXW + 2*NCH;
    localparam int HN = (WIN > 1) ? WIN - 1 : 1;
    localparam logic [AW:0]    DEPTH = (AW+1)'(2**AW);
    localparam logic [AW:0]    AFT   = (AW+1)'(AF_THRESH);
    localparam logic [BXW-1:0] BXM   = BXW'(BX_MAX);

    logic [BXW-1:0] bx;
    logic           cap_v;
    logic [BXW-1:0] cap_bx;
    logic [NCH-1:0] cap_ex;
    logic [31:0]    sr_v;
    logic [BXW-1:0] sr_bx [32];
    logic [NCH-1:0] sr_ex [32];
    logic [BXW-1:0] dp_bx;
    logic [NCH-1:0] dp_ex;

    logic [NCH-1:0] dl [16];
    logic [NCH-1:0] hist [HN];
    logic [NCH-1:0] dly;
    logic [NCH-1:0] davwin;

    logic [EW-1:0]  mem [2**AW];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    cnt;
    logic           wr;
    logic           rd;

    assign BXCOUNT = bx;
    assign WCOUNT  = cnt;
    assign FULL    = (cnt == DEPTH);
    assign AFULL   = (cnt >= AFT);
    assign EMPTY_B = (cnt != '0);
    assign wr      = DPUSH & ~FULL;
    assign rd      = POP & EMPTY_B;

    // Capture register plus a 32-deep line; tap PUSHDLY gives PUSHDLY+1 stages.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            bx     <= '0;
            cap_v  <= 1'b0;
            cap_bx <= '0;
            cap_ex <= '0;
            sr_v   <= '0;
            for (int i = 0; i < 32; i++) begin
                sr_bx[i] <= '0;
                sr_ex[i] <= '0;
            end
            DPUSH  <= 1'b0;
            dp_bx  <= '0;
            dp_ex  <= '0;
        end else begin
            bx     <= (BC0 || bx == BXM) ? '0 : bx + BXW'(1);
            cap_v  <= PUSH;
            cap_bx <= bx;
            cap_ex <= EXPECT;
            sr_v   <= {sr_v[30:0], cap_v};
            sr_bx[0] <= cap_bx;
            sr_ex[0] <= cap_ex;
            for (int i = 1; i < 32; i++) begin
                sr_bx[i] <= sr_bx[i-1];
                sr_ex[i] <= sr_ex[i-1];
            end
            DPUSH  <= sr_v[PUSHDLY];
            dp_bx  <= sr_bx[PUSHDLY];
            dp_ex  <= sr_ex[PUSHDLY];
        end
    end

    // dl[0] is the input register itself, so DAVDLY=0 taps it directly.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < 16; i++) dl[i] <= '0;
            for (int i = 0; i < HN; i++) hist[i] <= '0;
        end else begin
            dl[0] <= DAV & ~KILL;
            for (int i = 1; i < 16; i++) dl[i] <= dl[i-1];
            hist[0] <= dly;
            for (int i = 1; i < HN; i++) hist[i] <= hist[i-1];
        end
    end

    assign dly = dl[DAVDLY];

    always_comb begin
        davwin = dly;
        for (int j = 0; j < WIN - 1; j++) davwin = davwin | hist[j];
    end

    always_ff @(posedge CLK) begin
        if (wr) mem[wptr] <= {dp_bx, davwin, davwin ^ dp_ex};
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            DOUT_BX    <= '0;
            DOUT_DAV   <= '0;
            DOUT_ERR   <= '0;
            DOUT_VALID <= 1'b0;
            OVFL       <= 1'b0;
            UNFL       <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) begin
                rptr <= rptr + AW'(1);
                {DOUT_BX, DOUT_DAV, DOUT_ERR} <= mem[rptr];
            end
            cnt        <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
            DOUT_VALID <= rd;
            // A fresh error outranks a same-cycle clear.
            OVFL <= (OVFL & ~ERRCLR) | (DPUSH & FULL);
            UNFL <= (UNFL & ~ERRCLR) | (POP & ~EMPTY_B);
        end
    end

endmodule

// File: tb/tb_gtrg_dav_fifo_n.sv
// Scoreboard bench for gtrg_dav_fifo_n: queue-based reference model,
// random and directed stimulus, negedge monitor.
module tb_gtrg_dav_fifo_n;

    localparam int NCH   = 7;
    localparam int AW    = 10;
    localparam int BXW   = 12;
    localparam int BXMAX = 3563;
    localparam int WIN   = 5;
    localparam int AFT   = 1000;
    localparam int DEPTH = 1 << AW;
    localparam logic [BXW-1:0] BXM = BXW'(BXMAX);

    logic           CLK = 1'b0;
    logic           RST_B = 1'b1;
    logic           PUSH = 1'b0;
    logic           POP = 1'b0;
    logic           BC0 = 1'b0;
    logic           ERRCLR = 1'b0;
    logic [NCH-1:0] DAV = '0;
    logic [NCH-1:0] KILL = '0;
    logic [NCH-1:0] EXPECT = '0;
    logic [4:0]     PUSHDLY = '0;
    logic [3:0]     DAVDLY = '0;
    logic           DPUSH, EMPTY_B, FULL, AFULL, DOUT_VALID, OVFL, UNFL;
    logic [AW:0]    WCOUNT;
    logic [BXW-1:0] BXCOUNT, DOUT_BX;
    logic [NCH-1:0] DOUT_DAV, DOUT_ERR;

    gtrg_dav_fifo_n dut (
        .CLK(CLK), .RST_B(RST_B), .PUSH(PUSH), .POP(POP), .BC0(BC0),
        .DAV(DAV), .KILL(KILL), .EXPECT(EXPECT), .PUSHDLY(PUSHDLY),
        .DAVDLY(DAVDLY), .ERRCLR(ERRCLR), .DPUSH(DPUSH), .EMPTY_B(EMPTY_B),
        .FULL(FULL), .AFULL(AFULL), .WCOUNT(WCOUNT), .BXCOUNT(BXCOUNT),
        .DOUT_BX(DOUT_BX), .DOUT_DAV(DOUT_DAV), .DOUT_ERR(DOUT_ERR),
        .DOUT_VALID(DOUT_VALID), .OVFL(OVFL), .UNFL(UNFL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [BXW-1:0] bx;
        logic [NCH-1:0] dav;
        logic [NCH-1:0] err;
    } ent_t;
    typedef struct {
        int             w;
        logic [BXW-1:0] bx;
        logic [NCH-1:0] ex;
    } pend_t;
    typedef struct {
        ent_t e;
        int   stamp;
    } sb_t;

    ent_t           mq[$];
    pend_t          pq[$];
    sb_t            sbq[$];
    sb_t            s;
    logic [NCH-1:0] dk_hist [0:65535];
    int             cyc = 0;
    int             floor_c = 0;
    logic [BXW-1:0] mbx = '0;
    logic           movf = 1'b0;
    logic           munf = 1'b0;
    ent_t           mlast = '0;
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        pq.delete();
        sbq.delete();
        mbx     = '0;
        movf    = 1'b0;
        munf    = 1'b0;
        mlast   = '0;
        floor_c = cyc;
    endfunction

    // Reference: a push seen at edge e is written at edge e+PUSHDLY+3; its
    // window covers the masked DAV seen at edges w-1-DAVDLY-j, j<WIN.
    task automatic model_edge();
        int             occ;
        bit             dp, wr, rd;
        ent_t           e;
        logic [NCH-1:0] win;
        dk_hist[cyc] = DAV & ~KILL;
        occ = mq.size();
        dp  = (pq.size() > 0) && (pq[0].w == cyc);
        wr  = dp && (occ < DEPTH);
        rd  = POP && (occ > 0);
        if (rd) begin
            e = mq.pop_front();
            sbq.push_back('{e, cyc});
            mlast = e;
        end
        if (wr) begin
            win = '0;
            for (int j = 0; j < WIN; j++) begin
                int idx = cyc - 1 - int'(DAVDLY) - j;
                if (idx > floor_c) win = win | dk_hist[idx];
            end
            mq.push_back('{bx: pq[0].bx, dav: win, err: win ^ pq[0].ex});
        end
        if (dp) void'(pq.pop_front());
        movf = (movf & ~ERRCLR) | (dp && occ == DEPTH);
        munf = (munf & ~ERRCLR) | (POP && occ == 0);
        if (PUSH) pq.push_back('{cyc + int'(PUSHDLY) + 3, mbx, EXPECT});
        mbx = (BC0 || mbx == BXM) ? '0 : mbx + BXW'(1);
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        if (!RST_B) begin
            dk_hist[cyc] = '0;
            model_reset();
        end else begin
            model_edge();
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (DOUT_VALID) begin
            if (sbq.size() == 0) begin
                chk("dout_valid_spurious", 32'(DOUT_VALID), 32'(0));
            end else begin
                s = sbq.pop_front();
                chk("rd_bx", 32'(DOUT_BX), 32'(s.e.bx));
                chk("rd_dav", 32'(DOUT_DAV), 32'(s.e.dav));
                chk("rd_err", 32'(DOUT_ERR), 32'(s.e.err));
            end
        end else if (sbq.size() > 0 && sbq[0].stamp <= cyc) begin
            s = sbq.pop_front();
            chk("dout_valid_missing", 32'(DOUT_VALID), 32'(1));
        end
        chk("wcount", 32'(WCOUNT), 32'(mq.size()));
        chk("full", 32'(FULL), 32'(mq.size() == DEPTH));
        chk("afull", 32'(AFULL), 32'(mq.size() >= AFT));
        chk("empty_b", 32'(EMPTY_B), 32'(mq.size() != 0));
        chk("ovfl", 32'(OVFL), 32'(movf));
        chk("unfl", 32'(UNFL), 32'(munf));
        chk("bxcount", 32'(BXCOUNT), 32'(mbx));
        chk("dpush", 32'(DPUSH),
            32'(pq.size() > 0 && pq[0].w == cyc + 1));
        chk("dout_hold", 32'({DOUT_BX, DOUT_DAV, DOUT_ERR}), 32'(mlast));
    end

    initial begin
        #2 RST_B = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_wcount", 32'(WCOUNT), 32'(0));
        chk("rst_empty_b", 32'(EMPTY_B), 32'(0));
        chk("rst_bx", 32'(BXCOUNT), 32'(0));
        chk("rst_dpush", 32'(DPUSH), 32'(0));
        RST_B = 1'b1;

        repeat (9) tick();
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
        chk("bc0_zero", 32'(BXCOUNT), 32'(0));
        tick();
        chk("bc0_next", 32'(BXCOUNT), 32'(1));

        PUSHDLY = 5'd3;
        while (mbx != BXW'(100)) tick();
        PUSH = 1'b1;
        tick();
        PUSH = 1'b0;
        repeat (4) begin
            tick();
            chk("dpush_early", 32'(DPUSH), 32'(0));
        end
        tick();
        chk("dpush_lat5", 32'(DPUSH), 32'(1));
        tick();
        POP = 1'b1;
        tick();
        POP = 1'b0;
        chk("lat_valid", 32'(DOUT_VALID), 32'(1));
        chk("lat_bx100", 32'(DOUT_BX), 32'(100));
        tick();
        chk("lat_valid_pulse", 32'(DOUT_VALID), 32'(0));
        chk("lat_bx_hold", 32'(DOUT_BX), 32'(100));

        DAVDLY = 4'd2;
        EXPECT = 7'b0000011;
        KILL   = 7'b0000010;
        DAV    = 7'b0000010;
        repeat (20) tick();
        DAV = 7'b0000110;
        tick();
        DAV = 7'b0000010;
        tick();
        PUSH = 1'b1;
        tick();
        PUSH = 1'b0;
        tick();
        DAV = 7'b0000011;
        tick();
        DAV = 7'b0000010;
        repeat (4) tick();
        POP = 1'b1;
        tick();
        POP = 1'b0;
        chk("win_dav", 32'(DOUT_DAV), 32'(7'b0000001));
        chk("win_err", 32'(DOUT_ERR), 32'(7'b0000010));
        DAV  = '0;
        KILL = '0;

        for (int ph = 0; ph < 8; ph++) begin
            PUSH = 1'b0;
            POP  = 1'b0;
            BC0  = 1'b0;
            repeat (40) tick();
            PUSHDLY = 5'($urandom_range(0, 31));
            DAVDLY  = 4'($urandom_range(0, 15));
            KILL    = NCH'($urandom);
            repeat (30) tick();
            for (int i = 0; i < 500; i++) begin
                PUSH   = ($urandom_range(0, 99) < 25);
                POP    = ($urandom_range(0, 99) < 30);
                DAV    = NCH'($urandom);
                EXPECT = NCH'($urandom);
                BC0    = (ph == 7) && ($urandom_range(0, 99) < 2);
                ERRCLR = ($urandom_range(0, 99) < 3);
                tick();
            end
            ERRCLR = 1'b0;
        end
        PUSH = 1'b0;
        BC0  = 1'b0;
        repeat (40) tick();
        POP = 1'b1;
        while (mq.size() > 0) tick();
        POP    = 1'b0;
        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;

        PUSHDLY = 5'd0;
        PUSH    = 1'b1;
        for (int i = 0; i < DEPTH + 8; i++) begin
            DAV    = NCH'($urandom);
            EXPECT = NCH'($urandom);
            tick();
            if (mq.size() == AFT - 1) chk("afull_below", 32'(AFULL), 32'(0));
            if (mq.size() == AFT) chk("afull_at", 32'(AFULL), 32'(1));
            if (mq.size() == DEPTH - 1) chk("full_below", 32'(FULL), 32'(0));
        end
        chk("fill_full", 32'(FULL), 32'(1));
        chk("fill_wcount", 32'(WCOUNT), 32'(DEPTH));
        chk("fill_ovfl", 32'(OVFL), 32'(1));
        POP = 1'b1;
        tick();
        POP = 1'b0;
        chk("full_pp_wcount", 32'(WCOUNT), 32'(DEPTH - 1));
        chk("full_pp_ovfl", 32'(OVFL), 32'(1));
        PUSH = 1'b0;
        repeat (5) tick();
        POP = 1'b1;
        repeat (DEPTH + 4) tick();
        POP = 1'b0;
        chk("drain_empty_b", 32'(EMPTY_B), 32'(0));
        chk("drain_unfl", 32'(UNFL), 32'(1));

        ERRCLR = 1'b1;
        tick();
        chk("errclr_ovfl", 32'(OVFL), 32'(0));
        chk("errclr_unfl", 32'(UNFL), 32'(0));
        POP = 1'b1;
        tick();
        POP    = 1'b0;
        ERRCLR = 1'b0;
        chk("errclr_vs_unfl", 32'(UNFL), 32'(1));

        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;
        PUSH   = 1'b1;
        tick();
        PUSH = 1'b0;
        repeat (2) tick();
        POP = 1'b1;
        tick();
        POP = 1'b0;
        chk("empty_pp_wcount", 32'(WCOUNT), 32'(1));
        chk("empty_pp_unfl", 32'(UNFL), 32'(1));

        repeat (2) begin
            PUSH = 1'b1;
            tick();
            PUSH = 1'b0;
            tick();
        end
        repeat (5) tick();
        chk("pre_rst_wcount", 32'(WCOUNT), 32'(3));
        PUSHDLY = 5'd10;
        repeat (2) begin
            PUSH = 1'b1;
            tick();
            PUSH = 1'b0;
            tick();
        end
        #2 RST_B = 1'b0;
        model_reset();
        #1;
        chk("arst_wcount", 32'(WCOUNT), 32'(0));
        chk("arst_empty_b", 32'(EMPTY_B), 32'(0));
        chk("arst_unfl", 32'(UNFL), 32'(0));
        chk("arst_outs", 32'({DPUSH, FULL, AFULL, DOUT_VALID, OVFL}), 32'(0));
        chk("arst_bx", 32'(BXCOUNT), 32'(0));
        chk("arst_dout", 32'({DOUT_BX, DOUT_DAV, DOUT_ERR}), 32'(0));
        repeat (2) tick();
        RST_B = 1'b1;
        repeat (30) begin
            tick();
            chk("post_rst_dpush", 32'(DPUSH), 32'(0));
        end
        chk("post_rst_wcount", 32'(WCOUNT), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
